// File: rtl/seq_booth_multi.sv
// Radix-2 Booth sequential multiplier, unsigned or signed; fixed DP_WIDTH+1 cycle latency.
// start is ignored while busy; the result holds in DONE until the next accepted start.
module seq_booth_multi #(
  parameter int DP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [DP_WIDTH-1:0]     multiplier,
  input  logic [DP_WIDTH-1:0]     multiplicand,
  output logic [2*DP_WIDTH-1:0]   product,
  output logic                    ready,
  output logic                    busy
);

  localparam int W  = DP_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W+1:0]    acc;
  logic [W:0]      q;
  logic            q_1;
  logic [W+1:0]    mcand;
  logic [CW-1:0]   cnt;
  logic [W+1:0]    acc_sum;
  logic [2*W+3:0]  shifted;

  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
  end

  // {acc, q, q_1} shifted right arithmetically; the old q_1 falls off the bottom.
  assign shifted = {acc_sum[W+1], acc_sum, q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= '0;
            q     <= {signed_mode & multiplier[W-1], multiplier};
            q_1   <= 1'b0;
            mcand <= signed_mode ? {{2{multiplicand[W-1]}}, multiplicand}
                                 : {2'b00, multiplicand};
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= shifted[2*W+3:W+2];
          q   <= shifted[W+1:1];
          q_1 <= shifted[0];
          if (cnt == CW'(W)) begin
            product <= shifted[2*W:1];
            ready   <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multi.sv
// Scoreboarded bench: W=5 and W=8 instances checked against a plain-arithmetic product model.
module tb_seq_booth_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start5 = 1'b0, sm5 = 1'b0;
  logic [4:0]  mul5 = '0, mcd5 = '0;
  logic [9:0]  prod5;
  logic        rdy5, busy5;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  mul8 = '0, mcd8 = '0;
  logic [15:0] prod8;
  logic        rdy8, busy8;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] prod;
    int          k;
  } exp_t;

  exp_t q5[$];
  exp_t q8[$];

  seq_booth_multi #(.DP_WIDTH(5)) u5 (
    .clk(clk), .reset(reset), .start(start5), .signed_mode(sm5),
    .multiplier(mul5), .multiplicand(mcd5),
    .product(prod5), .ready(rdy5), .busy(busy5)
  );

  seq_booth_multi #(.DP_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .multiplier(mul8), .multiplicand(mcd8),
    .product(prod8), .ready(rdy8), .busy(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input bit s);
    longint x, y, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitors: pop the expected result on every rising edge of ready.
  logic prev5 = 1'b0, prev8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rdy5 && !prev5) begin
      if (q5.size() == 0) chk("unexpected_result5", 64'(prod5), 64'hx);
      else begin
        e = q5.pop_front();
        chk("product5", 64'(prod5), e.prod);
        chk("latency5", 64'(cyc - e.k), 64'd6);
      end
    end
    prev5 = rdy5;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy8 && !prev8) begin
      if (q8.size() == 0) chk("unexpected_result8", 64'(prod8), 64'hx);
      else begin
        e = q8.pop_front();
        chk("product8", 64'(prod8), e.prod);
        chk("latency8", 64'(cyc - e.k), 64'd9);
      end
    end
    prev8 = rdy8;
  end

  // One isolated multiply on the selected instance, with status checks along the way.
  task automatic go(input int w, input logic [7:0] a, input logic [7:0] b, input bit s);
    int k;
    logic [63:0] e;
    e = model(w, 32'(a), 32'(b), s);
    @(negedge clk);
    if (w == 5) begin mul5 = a[4:0]; mcd5 = b[4:0]; sm5 = s; start5 = 1'b1; end
    else begin mul8 = a; mcd8 = b; sm8 = s; start8 = 1'b1; end
    @(posedge clk);
    k = cyc + 1;
    if (w == 5) q5.push_back('{e, k}); else q8.push_back('{e, k});
    @(negedge clk);
    start5 = 1'b0;
    start8 = 1'b0;
    chk("busy_after_accept", 64'(w == 5 ? busy5 : busy8), 64'd1);
    repeat (w) @(posedge clk);
    @(negedge clk);
    chk("ready_before_last_step", 64'(w == 5 ? rdy5 : rdy8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("busy_when_done", 64'(w == 5 ? busy5 : busy8), 64'd0);
    repeat (2) @(negedge clk);
    chk("ready_held", 64'(w == 5 ? rdy5 : rdy8), 64'd1);
    chk("product_held", w == 5 ? 64'(prod5) : 64'(prod8), e);
  endtask

  initial begin
    logic [7:0] a, b;
    bit s;
    exp_t e;
    int k;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_product8", 64'(prod8), 64'd0);
    chk("reset_ready8", 64'(rdy8), 64'd0);
    chk("reset_busy8", 64'(busy8), 64'd0);
    chk("reset_product5", 64'(prod5), 64'd0);
    reset = 1'b0;

    go(5, 8'b01011, 8'b10111, 1'b0);
    go(5, 8'b01011, 8'b10111, 1'b1);
    go(8, 8'h80, 8'h80, 1'b1);
    go(8, 8'h80, 8'h7f, 1'b1);
    go(8, 8'hff, 8'hff, 1'b0);
    go(8, 8'h00, 8'hc3, 1'b1);
    go(8, 8'h5a, 8'h00, 1'b0);
    go(8, 8'hff, 8'hff, 1'b1);

    // start pulse and operand churn during RUN must not disturb the in-flight result
    @(negedge clk);
    mul8 = 8'h9c; mcd8 = 8'h37; sm8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    q8.push_back('{model(8, 32'h9c, 32'h37, 1'b1), cyc + 1});
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      start8 = (j == 3);
      mul8 = 8'($urandom); mcd8 = 8'($urandom); sm8 = 1'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_ready_held", 64'(rdy8), 64'd1);

    // reset 4 cycles into RUN, with start also high, aborts the operation
    @(negedge clk);
    mul8 = 8'h3b; mcd8 = 8'hd1; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_product", 64'(prod8), 64'd0);
    chk("abort_ready", 64'(rdy8), 64'd0);
    chk("abort_busy", 64'(busy8), 64'd0);
    reset = 1'b0; start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_result", 64'(rdy8), 64'd0);
    go(8, 8'h3b, 8'hd1, 1'b0);

    // start held high: a fresh operation accepted on each first DONE edge
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
    mul8 = a; mcd8 = b; sm8 = s; start8 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      k = cyc + 1;
      e.prod = model(8, 32'(a), 32'(b), s);
      e.k = k;
      q8.push_back(e);
      @(negedge clk);
      if (i > 0) chk("ready_single_cycle", 64'(rdy8), 64'd0);
      mul8 = 8'($urandom); mcd8 = 8'($urandom); sm8 = 1'($urandom);
      repeat (9) @(posedge clk);
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      mul8 = a; mcd8 = b; sm8 = s;
      start8 = (i < 15);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard5_drained", 64'(q5.size()), 64'd0);
    chk("scoreboard8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
